dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory (11-bit byte address, 32-bit data, 4-bit byte mask, synchronous write, combinational read) between the load/store unit (master 0) and a DMA/debug master (master 1). Grants at most one access per cycle using round-robin priority, with an optional bounded lock for back-to-back beats. Registers the read data into a per-master response. Sits between the LSU/DMA and the data memory.

Parameters:
ADDR_W, 11, byte-address width presented to memory
MAX_LOCK, 4, maximum consecutive beats one master may hold the memory via lock (>=1)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous active-low reset
i_m0_req / i_m1_req  in  1  access request, held until granted
i_m0_lock / i_m1_lock  in  1  request to keep grant for the next beat
i_m0_addr / i_m1_addr  in  ADDR_W  byte address
i_m0_wdata / i_m1_wdata  in  32  store data
i_m0_bmask / i_m1_bmask  in  4  1111 word, 0011 half, 0001 byte
i_m0_wren / i_m1_wren  in  1  1 = store, 0 = load
o_m0_gnt / o_m1_gnt  out  1  combinational; request accepted this cycle
o_m0_rvalid / o_m1_rvalid  out  1  one-cycle response pulse, cycle after grant
o_m0_rdata / o_m1_rdata  out  32  registered load data; 0 for stores and errors
o_m0_err / o_m1_err  out  1  qualifies rvalid; illegal bmask
o_mem_addr  out  ADDR_W  to memory i_addr
o_mem_wdata  out  32  to memory i_wdata
o_mem_bmask  out  4  to memory i_bmask
o_mem_wren  out  1  to memory i_wren
i_mem_rdata  in  32  from memory o_rdata, combinational

Behaviour:
- Reset (i_reset=0, async): rr_ptr=0 (master 0 preferred), state IDLE, lock_cnt=0. All o_*_rvalid, o_*_err = 0 and o_*_rdata = 0. Any in-flight response is dropped.
- Grant, combinational, exactly one or zero o_mN_gnt:
  - IDLE: only one req -> grant it. Both req -> grant master rr_ptr.
  - LOCKED(owner): owner req=1 -> grant owner. Owner req=0 -> arbitrate as in IDLE in the same cycle.
- Memory mux: o_mem_* driven from the granted master. No grant -> addr=0, wdata=0, bmask=0000, wren=0.
- Legality: bmask not in {1111, 0011, 0001} -> access granted but o_mem_wren forced 0 and o_mem_bmask=0000. Response has err=1 and rdata=0.
- Write happens in the grant cycle at the clock edge. Read data is sampled from i_mem_rdata in the grant cycle.
- Response, at the next edge after grant N:
  - o_mN_rvalid=1 for exactly 1 cycle.
  - o_mN_rdata = sampled data for a legal load; 0 otherwise.
  - Other master's rvalid=0.
  - Non-granted cycle -> all rvalid=0; rdata holds its last value.
- Throughput: 1 access per cycle. Load latency 1 cycle. Back-to-back grants give back-to-back rvalid.
- rr_ptr: after any grant to master N, rr_ptr = 1-N. It does not change in cycles with no grant.
- Lock FSM:
  - IDLE -> LOCKED(N) when N is granted with lock=1 and MAX_LOCK>1; lock_cnt=1.
  - In LOCKED, each owner grant with lock=1 increments lock_cnt.
  - Owner grant with lock=0, or owner not requesting -> IDLE.
  - lock_cnt reaching MAX_LOCK on a grant -> IDLE, with rr_ptr pointing at the other master. The other master, if requesting, wins the next cycle.
  - Lock never blocks a non-requesting-owner cycle, so there are no idle bubbles.
- Simultaneous events:
  - Owner releases and the other master requests in the same cycle -> other master is granted that cycle.
  - Reset asserted mid-lock -> IDLE immediately.
- Masters must hold addr/wdata/bmask/wren/lock stable while req=1 and gnt=0. The arbiter does not buffer requests.

Test Plan:
- Single access: m0 stores 0xDEADBEEF at 0x010 (bmask 1111), then loads 0x010 -> writes visible on o_mem_*; next load gives o_m0_rvalid=1, rdata 0xDEADBEEF, err=0.
- Contention: m0 and m1 request loads every cycle for 6 cycles after reset -> grants m0,m1,m0,m1,m0,m1; each rvalid exactly one cycle after its grant.
- Lock with MAX_LOCK=4: m1 holds req+lock for 6 beats while m0 requests continuously -> m1 granted 4 consecutive cycles, m0 granted 5th, m1 6th.
- Illegal mask: m0 store with bmask 0101 to 0x020 holding 0x12345678 -> o_mem_wren=0; next cycle rvalid=1, err=1, rdata=0; subsequent load of 0x020 returns 0x12345678.
- Idle/pointer hold: m1 granted once, 3 idle cycles, then both request -> m0 granted (rr_ptr held at 0); idle cycles show bmask=0000, wren=0.
- Reset mid-lock: m0 locked at lock_cnt=2, i_reset pulled low between edges -> rvalid/err/rdata cleared immediately; after release, both requesting -> m0 granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter with bounded lock sharing one data memory between two masters
//
// Purpose: grants at most one memory access per cycle to either the LSU
// (master 0) or the DMA/debug master (master 1). Priority alternates; a
// master may hold the memory for up to MAX_LOCK consecutive beats by
// asserting lock. Load data is registered into a per-master response.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_mN_req/lock           request (held until granted), keep-grant hint
//   i_mN_addr/wdata/bmask   byte address, store data, byte mask
//   i_mN_wren               1 = store, 0 = load
//   o_mN_gnt                combinational grant for this cycle
//   o_mN_rvalid/rdata/err   one-cycle response in the cycle after the grant
//   o_mem_*                 request forwarded to the memory
//   i_mem_rdata             combinational read data from the memory
module dmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int MAX_LOCK = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m0_lock,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [31:0]       i_m0_wdata,
  input  logic [3:0]        i_m0_bmask,
  input  logic              i_m0_wren,
  input  logic              i_m1_req,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [31:0]       i_m1_wdata,
  input  logic [3:0]        i_m1_bmask,
  input  logic              i_m1_wren,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [31:0]       o_m0_rdata,
  output logic              o_m0_err,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [31:0]       o_m1_rdata,
  output logic              o_m1_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);
  localparam bit               LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;

  logic              owner_hold;
  logic              gnt0, gnt1, gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_bmask;
  logic              sel_wren, sel_lock, legal;
  logic [31:0]       rd_val;
  logic [CNT_W-1:0]  cnt_inc;

  // The lock only binds while its owner keeps requesting; otherwise the
  // cycle falls through to normal arbitration so no bubble is inserted.
  assign owner_hold = (state_q == ST_LOCKED) && (owner_q ? i_m1_req : i_m0_req);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (owner_hold) begin
      gnt0 = ~owner_q;
      gnt1 = owner_q;
    end else if (i_m0_req && i_m1_req) begin
      gnt0 = ~rr_q;
      gnt1 = rr_q;
    end else begin
      gnt0 = i_m0_req;
      gnt1 = i_m1_req;
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign sel_addr  = gnt1 ? i_m1_addr  : i_m0_addr;
  assign sel_wdata = gnt1 ? i_m1_wdata : i_m0_wdata;
  assign sel_bmask = gnt1 ? i_m1_bmask : i_m0_bmask;
  assign sel_wren  = gnt1 ? i_m1_wren  : i_m0_wren;
  assign sel_lock  = gnt1 ? i_m1_lock  : i_m0_lock;
  assign legal     = (sel_bmask == 4'b1111) || (sel_bmask == 4'b0011) ||
                     (sel_bmask == 4'b0001);

  // Illegal masks are still granted (so the master sees an error response)
  // but never reach the memory as a write.
  assign o_mem_addr  = gnt_any ? sel_addr  : '0;
  assign o_mem_wdata = gnt_any ? sel_wdata : '0;
  assign o_mem_bmask = (gnt_any && legal) ? sel_bmask : 4'b0000;
  assign o_mem_wren  = gnt_any && legal && sel_wren;

  assign rd_val  = (legal && !sel_wren) ? i_mem_rdata : 32'h0;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    rvalid_d = {gnt1, gnt0};
    err_d    = {gnt1 & ~legal, gnt0 & ~legal};
    rdata0_d = gnt0 ? rd_val : rdata0_q;
    rdata1_d = gnt1 ? rd_val : rdata1_q;
    if (gnt_any) begin
      rr_d = ~gnt1;
      if (owner_hold) begin
        // Owner beat: extend the lock until it is dropped or exhausted.
        if (sel_lock && (cnt_inc < MAX_CNT)) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end else if (sel_lock && LOCK_EN) begin
        state_d = ST_LOCKED;
        owner_d = gnt1;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign o_m0_gnt    = gnt0;
  assign o_m1_gnt    = gnt1;
  assign o_m0_rvalid = rvalid_q[0];
  assign o_m1_rvalid = rvalid_q[1];
  assign o_m0_err    = err_q[0];
  assign o_m1_err    = err_q[1];
  assign o_m0_rdata  = rdata0_q;
  assign o_m1_rdata  = rdata1_q;

endmodule
